idu_issue_ctrl: RTL and testbench
=================================

Name: idu_issue_ctrl

Overview:
- Issue/hazard controller for the decode stage; decides each cycle whether the instruction held in the decode pipe register may issue to EX.
- Keeps a 32-entry register scoreboard for long-latency results (loads, mul/div) and an outstanding-operation counter.
- Drains all outstanding operations before a CSR access, and inserts bubbles after a jump/flush.
- Drives hold_flag toward ctrl so PC/IF/ID freeze while issue is blocked.

Parameters:
MAX_OUTSTANDING, 4, maximum in-flight long-latency ops (1..15).
FLUSH_CYCLES, 1, bubble cycles after jump_flush_i (1..7).

Ports:
clk  input  1  clock, all state on rising edge
rst  input  1  asynchronous, active-high reset
issue_valid_i  input  1  decode holds a valid instruction
issue_rs1_i  input  5  source register 1
issue_rs1_used_i  input  1  rs1 is read
issue_rs2_i  input  5  source register 2
issue_rs2_used_i  input  1  rs2 is read
issue_rd_i  input  5  destination register
issue_rd_we_i  input  1  instruction writes rd
issue_long_i  input  1  result returns later via wb port
issue_csr_i  input  1  CSR access instruction
ex_busy_i  input  1  EX cannot accept this cycle
wb_valid_i  input  1  a long op completes
wb_rd_i  input  5  register written by completing long op
jump_flush_i  input  1  EX redirect, flush younger instructions
issue_ready_o  output  1  instruction issues this cycle (fire = issue_valid_i & issue_ready_o)
hold_flag_o  output  3  0=none, 3=hold PC/IF/ID
sb_pending_o  output  32  scoreboard bits, bit0 always 0
outstanding_o  output  4  in-flight long-op count
err_o  output  1  sticky: wb_valid_i with count 0

Behaviour:
- Reset (async, while rst=1): state=RUN, pending=0, count=0, flush counter=0, err_o=0; issue_ready_o=0 and hold_flag_o=0 forced while rst is asserted.
- Hazards use only registered pending; there is no same-cycle wb bypass.
  - raw = (rs1_used & pending[rs1]) | (rs2_used & pending[rs2]).
  - waw = rd_we & pending[rd].
  - full = long & (count==MAX_OUTSTANDING).
- States: RUN, DRAIN, FLUSH.
- issue_ready_o = state==RUN & !raw & !waw & !full & !ex_busy_i & !jump_flush_i & !(issue_csr_i & count!=0).
- hold_flag_o = 3 when issue_valid_i & !issue_ready_o & state!=FLUSH & !jump_flush_i; else 0. FLUSH bubbles are not holds.
- Transitions, in priority order:
  - jump_flush_i from any state -> FLUSH, flush counter loaded with FLUSH_CYCLES.
  - FLUSH: counter decrements each cycle; -> RUN on the cycle it reaches 0. A new jump_flush_i reloads the counter.
  - RUN: issue_valid_i & issue_csr_i & count!=0 -> DRAIN.
  - DRAIN: -> RUN when count==0 (registered). The CSR instruction issues in RUN the following cycle.
- Scoreboard update:
  - On fire & rd_we & long & rd!=0: set pending[rd].
  - On wb_valid_i: clear pending[wb_rd_i].
  - Same register set and cleared in one cycle: set wins.
  - x0 is never set.
- Counter update:
  - +1 on fire & long; -1 on wb_valid_i; both in one cycle -> unchanged.
  - wb_valid_i with count==0: count stays 0 and err_o sets (cleared only by rst).
  - Count never exceeds MAX_OUTSTANDING, because full blocks issue.
- Flush does not clear pending bits or count; already-issued long ops still write back.
- A short op (long=0) with rd_we does not touch the scoreboard; its forwarding is handled in EX.
- Latency: issue decision is combinational in the same cycle; scoreboard/count effects are visible one cycle after fire or wb.

Test Plan:
- Issue long load rd=5 (fire at t0), then an instruction with rs1=5 at t1 -> ready=0, hold=3 until wb_valid(rd=5) at t4; ready=1 at t5; sb_pending_o[5] is 1 during t1..t4 and 0 at t5.
- Issue MAX_OUTSTANDING=4 long ops to rd=1..4 -> outstanding_o=4; fifth long op stalls (hold=3); one wb_valid -> count=3 and the fifth issues the next cycle.
- CSR instruction with count=2 -> state DRAIN, ready=0, hold=3; two wb_valid -> count=0, RUN, CSR fires one cycle later.
- jump_flush_i pulse with FLUSH_CYCLES=1 while a hazard is pending -> ready=0 and hold=0 for the flush cycle plus one FLUSH cycle; pending bits retained.
- Same-cycle fire(long, rd=7) and wb_valid(rd=7) with count=1 -> pending[7]=1, count=1; wb_valid with count=0 -> err_o=1 and stays set.
- Assert rst mid-DRAIN with count=3 -> immediately ready=0, hold=0; after release: RUN, count=0, sb_pending_o=0.

Source files
------------

// File: rtl/idu_issue_ctrl.sv
// Decode-stage issue controller: scoreboards long-latency results, drains
// outstanding ops before CSR access and inserts bubbles after a redirect.
module idu_issue_ctrl #(
   parameter int MAX_OUTSTANDING = 4,
   parameter int FLUSH_CYCLES    = 1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        issue_valid_i,
   input  logic [4:0]  issue_rs1_i,
   input  logic        issue_rs1_used_i,
   input  logic [4:0]  issue_rs2_i,
   input  logic        issue_rs2_used_i,
   input  logic [4:0]  issue_rd_i,
   input  logic        issue_rd_we_i,
   input  logic        issue_long_i,
   input  logic        issue_csr_i,
   input  logic        ex_busy_i,
   input  logic        wb_valid_i,
   input  logic [4:0]  wb_rd_i,
   input  logic        jump_flush_i,
   output logic        issue_ready_o,
   output logic [2:0]  hold_flag_o,
   output logic [31:0] sb_pending_o,
   output logic [3:0]  outstanding_o,
   output logic        err_o
);

   typedef enum logic [1:0] {RUN, DRAIN, FLUSH} state_t;

   state_t      state_reg;
   logic [31:0] pending_reg;
   logic [31:0] pending_next;
   logic [3:0]  count_reg;
   logic [3:0]  count_next;
   logic [2:0]  flush_cnt_reg;
   logic        err_reg;

   logic raw;
   logic waw;
   logic full;
   logic csr_block;
   logic fire;
   logic inc;
   logic dec;

   // Hazards look only at registered pending bits; a same-cycle writeback
   // does not unblock the consumer.
   assign raw       = (issue_rs1_used_i & pending_reg[issue_rs1_i]) |
                      (issue_rs2_used_i & pending_reg[issue_rs2_i]);
   assign waw       = issue_rd_we_i & pending_reg[issue_rd_i];
   assign full      = issue_long_i & (count_reg == 4'(MAX_OUTSTANDING));
   assign csr_block = issue_csr_i & (count_reg != 4'd0);

   assign issue_ready_o = !rst && (state_reg == RUN) && !raw && !waw && !full &&
                          !ex_busy_i && !jump_flush_i && !csr_block;
   assign fire          = issue_valid_i & issue_ready_o;

   // Flush bubbles are not holds: the front end is being redirected anyway.
   assign hold_flag_o = (!rst && issue_valid_i && !issue_ready_o &&
                         (state_reg != FLUSH) && !jump_flush_i) ? 3'd3 : 3'd0;

   assign inc = fire & issue_long_i;
   assign dec = wb_valid_i;

   assign pending_next[0] = 1'b0;
   generate
      for (genvar gi = 1; gi < 32; gi++) begin : g_sb
         logic set_bit;
         logic clr_bit;
         assign set_bit = fire & issue_rd_we_i & issue_long_i & (issue_rd_i == 5'(gi));
         assign clr_bit = wb_valid_i & (wb_rd_i == 5'(gi));
         assign pending_next[gi] = set_bit | (pending_reg[gi] & !clr_bit);
      end
   endgenerate

   always_comb begin
      count_next = count_reg;
      if (inc && !dec)
         count_next = count_reg + 4'd1;
      else if (!inc && dec && (count_reg != 4'd0))
         count_next = count_reg - 4'd1;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg     <= RUN;
         pending_reg   <= '0;
         count_reg     <= '0;
         flush_cnt_reg <= '0;
         err_reg       <= 1'b0;
      end else begin
         pending_reg <= pending_next;
         count_reg   <= count_next;
         if (wb_valid_i && (count_reg == 4'd0))
            err_reg <= 1'b1;

         if (jump_flush_i) begin
            state_reg     <= FLUSH;
            flush_cnt_reg <= 3'(FLUSH_CYCLES);
         end else begin
            case (state_reg)
               RUN: begin
                  if (issue_valid_i && csr_block)
                     state_reg <= DRAIN;
               end
               DRAIN: begin
                  if (count_reg == 4'd0)
                     state_reg <= RUN;
               end
               FLUSH: begin
                  if (flush_cnt_reg <= 3'd1) begin
                     flush_cnt_reg <= 3'd0;
                     state_reg     <= RUN;
                  end else begin
                     flush_cnt_reg <= flush_cnt_reg - 3'd1;
                  end
               end
               default: state_reg <= RUN;
            endcase
         end
      end
   end

   assign sb_pending_o  = pending_reg;
   assign outstanding_o = count_reg;
   assign err_o         = err_reg;

endmodule

// File: tb/tb_idu_issue_ctrl.sv
// Directed bench for idu_issue_ctrl (MAX_OUTSTANDING=4, FLUSH_CYCLES=1):
// expected values are hand-derived per vector.
module tb_idu_issue_ctrl;

   logic        clk;
   logic        rst;
   logic        valid;
   logic [4:0]  rs1;
   logic        rs1u;
   logic [4:0]  rs2;
   logic        rs2u;
   logic [4:0]  rd;
   logic        we;
   logic        lng;
   logic        csr;
   logic        busy;
   logic        wb;
   logic [4:0]  wbrd;
   logic        jump;
   logic        ready;
   logic [2:0]  hold;
   logic [31:0] sb;
   logic [3:0]  outst;
   logic        err;

   int checks = 0;
   int errors = 0;

   idu_issue_ctrl #(.MAX_OUTSTANDING(4), .FLUSH_CYCLES(1)) dut (
      .clk(clk), .rst(rst),
      .issue_valid_i(valid), .issue_rs1_i(rs1), .issue_rs1_used_i(rs1u),
      .issue_rs2_i(rs2), .issue_rs2_used_i(rs2u), .issue_rd_i(rd),
      .issue_rd_we_i(we), .issue_long_i(lng), .issue_csr_i(csr),
      .ex_busy_i(busy), .wb_valid_i(wb), .wb_rd_i(wbrd), .jump_flush_i(jump),
      .issue_ready_o(ready), .hold_flag_o(hold), .sb_pending_o(sb),
      .outstanding_o(outst), .err_o(err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=0x%0h exp=0x%0h t=%0t", tag, got, exp, $time);
      end else begin
         $display("ok   %s = 0x%0h", tag, got);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      valid = 0; rs1 = 0; rs1u = 0; rs2 = 0; rs2u = 0; rd = 0; we = 0;
      lng = 0; csr = 0; busy = 0; wb = 0; wbrd = 0; jump = 0;
   endtask

   initial begin
      rst = 1'b1;
      idle();
      valid = 1;
      #1;
      check("rst_ready", 32'(ready), 32'd0);
      check("rst_hold", 32'(hold), 32'd0);
      check("rst_sb", sb, 32'd0);
      check("rst_outst", 32'(outst), 32'd0);
      check("rst_err", 32'(err), 32'd0);
      tick();
      tick();
      rst = 1'b0;
      idle();

      // Load to x5, then a consumer of x5 stalls until the wb is registered
      valid = 1; rd = 5; we = 1; lng = 1;
      #1 check("ld5_ready", 32'(ready), 32'd1);
      tick();
      idle(); valid = 1; rs1 = 5; rs1u = 1;
      for (int i = 0; i < 3; i++) begin
         #1;
         check("raw_ready", 32'(ready), 32'd0);
         check("raw_hold", 32'(hold), 32'd3);
         check("raw_sb5", 32'(sb[5]), 32'd1);
         check("raw_outst", 32'(outst), 32'd1);
         tick();
      end
      wb = 1; wbrd = 5;
      #1 check("raw_nobypass", 32'(ready), 32'd0);
      check("raw_sb5_wb", 32'(sb[5]), 32'd1);
      tick();
      wb = 0;
      #1 check("raw_release", 32'(ready), 32'd1);
      check("raw_sb5_clr", 32'(sb[5]), 32'd0);
      check("raw_outst0", 32'(outst), 32'd0);
      tick();

      // Fill to MAX_OUTSTANDING, fifth long op blocked until one wb
      idle(); valid = 1; we = 1; lng = 1;
      for (int i = 1; i <= 4; i++) begin
         rd = 5'(i);
         #1 check("fill_ready", 32'(ready), 32'd1);
         tick();
      end
      rd = 6;
      #1 check("full_outst", 32'(outst), 32'd4);
      check("full_sb", sb, 32'h0000_001E);
      check("full_ready", 32'(ready), 32'd0);
      check("full_hold", 32'(hold), 32'd3);
      wb = 1; wbrd = 1;
      #1 check("full_wb_same", 32'(ready), 32'd0);
      tick();
      wb = 0;
      #1 check("full_outst3", 32'(outst), 32'd3);
      check("full_issue", 32'(ready), 32'd1);
      tick();
      idle();
      #1 check("full_outst4", 32'(outst), 32'd4);
      check("full_sb2", sb, 32'h0000_005C);
      wb = 1; wbrd = 2;
      tick();
      wbrd = 3;
      tick();
      wb = 0;
      #1 check("pre_csr_outst", 32'(outst), 32'd2);
      check("pre_csr_sb", sb, 32'h0000_0050);

      // CSR drains the two remaining ops, issues one cycle after count==0
      valid = 1; csr = 1;
      #1 check("csr_ready", 32'(ready), 32'd0);
      check("csr_hold", 32'(hold), 32'd3);
      tick();
      wb = 1; wbrd = 4;
      #1 check("drain_ready", 32'(ready), 32'd0);
      check("drain_hold", 32'(hold), 32'd3);
      tick();
      wbrd = 6;
      #1 check("drain_outst1", 32'(outst), 32'd1);
      check("drain_ready2", 32'(ready), 32'd0);
      tick();
      wb = 0;
      #1 check("drain_outst0", 32'(outst), 32'd0);
      check("drain_ready3", 32'(ready), 32'd0);
      check("drain_hold3", 32'(hold), 32'd3);
      tick();
      #1 check("csr_fire", 32'(ready), 32'd1);
      tick();
      idle();

      // Flush while a RAW hazard is pending
      valid = 1; rd = 9; we = 1; lng = 1;
      #1 check("ld9_ready", 32'(ready), 32'd1);
      tick();
      idle(); valid = 1; rs1 = 9; rs1u = 1;
      #1 check("pre_flush_hold", 32'(hold), 32'd3);
      jump = 1;
      #1 check("jump_ready", 32'(ready), 32'd0);
      check("jump_hold", 32'(hold), 32'd0);
      tick();
      jump = 0;
      #1 check("flush_ready", 32'(ready), 32'd0);
      check("flush_hold", 32'(hold), 32'd0);
      tick();
      #1 check("post_flush_hold", 32'(hold), 32'd3);
      check("post_flush_sb9", 32'(sb[9]), 32'd1);
      check("post_flush_outst", 32'(outst), 32'd1);
      wb = 1; wbrd = 9;
      tick();
      wb = 0;
      #1 check("post_flush_issue", 32'(ready), 32'd1);
      tick();
      idle();

      // Same-cycle set/clear of x7: set wins, count unchanged; then underflow
      valid = 1; rd = 8; we = 1; lng = 1;
      #1 check("ld8_ready", 32'(ready), 32'd1);
      tick();
      rd = 7; wb = 1; wbrd = 7;
      #1 check("ld7_ready", 32'(ready), 32'd1);
      tick();
      idle();
      #1 check("setwins_sb", sb, 32'h0000_0180);
      check("setwins_outst", 32'(outst), 32'd1);
      wb = 1; wbrd = 7;
      tick();
      wbrd = 8;
      #1 check("pre_uf_err", 32'(err), 32'd0);
      check("pre_uf_outst", 32'(outst), 32'd0);
      tick();
      wb = 0;
      #1 check("uf_err", 32'(err), 32'd1);
      check("uf_outst", 32'(outst), 32'd0);
      check("uf_sb", sb, 32'd0);
      tick();
      tick();
      #1 check("uf_err_sticky", 32'(err), 32'd1);

      // x0 never scoreboarded; reset mid-DRAIN with count=3
      valid = 1; we = 1; lng = 1; rd = 0;
      tick();
      rd = 10;
      tick();
      rd = 11;
      tick();
      idle();
      #1 check("x0_outst", 32'(outst), 32'd3);
      check("x0_sb", sb, 32'h0000_0C00);
      valid = 1; csr = 1;
      tick();
      #1 check("drain2_ready", 32'(ready), 32'd0);
      check("drain2_hold", 32'(hold), 32'd3);
      rst = 1;
      #1 check("arst_ready", 32'(ready), 32'd0);
      check("arst_hold", 32'(hold), 32'd0);
      check("arst_outst", 32'(outst), 32'd0);
      check("arst_sb", sb, 32'd0);
      check("arst_err", 32'(err), 32'd0);
      tick();
      rst = 0;
      #1 check("post_rst_csr_ready", 32'(ready), 32'd1);
      tick();
      idle();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
